// File: rtl/crack_pkg.sv
// rtl/crack_pkg.sv - shared state type, default geometry and chunk helper for the key-space scheduler
package crack_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_e;

   localparam int KEY_W_DEF      = 24;
   localparam int CHUNK_LOG2_DEF = 16;
   localparam int NCHUNK         = 2 ** (KEY_W_DEF - CHUNK_LOG2_DEF);
   localparam int CHUNK_W        = KEY_W_DEF - CHUNK_LOG2_DEF + 1;

   function automatic logic [31:0] chunk_base(input logic [31:0] chunk, input int unsigned log2);
      return chunk << log2;
   endfunction

endpackage

// File: rtl/sched_min_key.sv
// rtl/sched_min_key.sv - combinational minimum over the keys of cores reporting a hit this cycle
module sched_min_key
   import crack_pkg::*;
#(
   parameter int NCORES     = 2,
   parameter int KEY_W      = 24,
   parameter int CHUNK_LOG2 = 16,
   parameter int CW         = KEY_W - CHUNK_LOG2 + 1
) (
   input  logic [NCORES-1:0]       i_valid,
   input  logic [NCORES*KEY_W-1:0] i_keys,
   output logic                    o_hit,
   output logic [KEY_W-1:0]        o_key,
   output logic [CW-1:0]           o_chunk
);

   logic             w_hit;
   logic [KEY_W-1:0] w_key;

   always_comb begin
      w_hit = 1'b0;
      w_key = '0;
      for (int i = 0; i < NCORES; i++) begin
         if (i_valid[i] && (!w_hit || i_keys[i*KEY_W +: KEY_W] < w_key)) begin
            w_hit = 1'b1;
            w_key = i_keys[i*KEY_W +: KEY_W];
         end
      end
   end

   assign o_hit   = w_hit;
   assign o_key   = w_key;
   assign o_chunk = CW'(w_key >> CHUNK_LOG2);

endmodule

// File: rtl/crack_scheduler.sv
// rtl/crack_scheduler.sv - chunked key-space dispatcher returning the lowest hit over NCORES crack cores
// Optional CRACK_SCHED_PROGRESS_EN adds o_chunks_done (completed plus aborted chunks).
module crack_scheduler
   import crack_pkg::*;
#(
   parameter int NCORES     = 2,
   parameter int KEY_W      = 24,
   parameter int CHUNK_LOG2 = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_en,
   output logic                      o_rdy,
   output logic [KEY_W-1:0]          o_key,
   output logic                      o_key_valid,
   output logic [NCORES-1:0]         o_core_en,
   output logic [KEY_W-1:0]          o_core_base,
   output logic [KEY_W-1:0]          o_core_last,
   output logic [NCORES-1:0]         o_core_abort,
   input  logic [NCORES-1:0]         i_core_rdy,
   input  logic [NCORES-1:0]         i_core_done,
   input  logic [NCORES-1:0]         i_core_found,
   input  logic [NCORES*KEY_W-1:0]   i_core_key
`ifdef CRACK_SCHED_PROGRESS_EN
   ,
   output logic [KEY_W-CHUNK_LOG2:0] o_chunks_done
`endif
);

   localparam int                CW       = KEY_W - CHUNK_LOG2 + 1;
   localparam logic [CW-1:0]     C_NCHUNK = {1'b1, {(CW-1){1'b0}}};
   localparam logic [KEY_W-1:0]  C_SPAN   = KEY_W'((64'd1 << CHUNK_LOG2) - 64'd1);

   sched_state_e      r_state, w_state_nxt;
   logic [NCORES-1:0] r_busy, r_abort, r_core_en;
   logic [CW-1:0]     r_chunk_id [NCORES];
   logic [CW-1:0]     r_next_chunk, r_best_chunk;
   logic [KEY_W-1:0]  r_best_key, r_key, r_core_base, r_core_last;
   logic              r_hit, r_key_valid;

   logic [NCORES-1:0] w_disp, w_done_ok, w_abort_clr, w_busy_nxt;
   logic              w_min_hit, w_best_upd, w_run_end, w_accept;
   logic [KEY_W-1:0]  w_min_key, w_base;
   logic [CW-1:0]     w_min_chunk, w_best_chunk_nxt, w_next_chunk_nxt;

   // Lowest-index idle core wins; chunks past the current best can never produce a lower key.
   always_comb begin
      w_disp = '0;
      if (r_state == RUN && r_next_chunk < C_NCHUNK && r_next_chunk < r_best_chunk) begin
         for (int i = NCORES - 1; i >= 0; i--) begin
            if (i_core_rdy[i] && !r_busy[i] && !r_abort[i]) begin
               w_disp    = '0;
               w_disp[i] = 1'b1;
            end
         end
      end
   end

   assign w_done_ok   = i_core_done & r_busy & ~r_abort;
   assign w_abort_clr = r_abort & i_core_rdy;
   assign w_busy_nxt  = (r_busy & ~w_done_ok & ~w_abort_clr) | w_disp;
   assign w_accept    = (r_state == IDLE) && i_en;
   assign w_base      = KEY_W'(chunk_base(32'(r_next_chunk), CHUNK_LOG2));

   sched_min_key #(.NCORES(NCORES), .KEY_W(KEY_W), .CHUNK_LOG2(CHUNK_LOG2), .CW(CW)) u_min_key (
      .i_valid (w_done_ok & i_core_found),
      .i_keys  (i_core_key),
      .o_hit   (w_min_hit),
      .o_key   (w_min_key),
      .o_chunk (w_min_chunk)
   );

   assign w_best_upd       = w_min_hit && (!r_hit || w_min_key < r_best_key);
   assign w_best_chunk_nxt = w_best_upd ? w_min_chunk : r_best_chunk;
   assign w_next_chunk_nxt = r_next_chunk + CW'(|w_disp);
   // Evaluated on post-edge values so the last done reaches DONE on the same edge.
   assign w_run_end        = (w_busy_nxt == '0) &&
                             (w_next_chunk_nxt == C_NCHUNK || w_best_chunk_nxt < w_next_chunk_nxt);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (i_en)      w_state_nxt = RUN;
         RUN:     if (w_run_end) w_state_nxt = DONE;
         DONE:                   w_state_nxt = IDLE;
         default:                w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_rdy = (r_state == IDLE);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_busy       <= '0;
         r_abort      <= '0;
         r_core_en    <= '0;
         r_core_base  <= '0;
         r_core_last  <= '0;
         r_next_chunk <= '0;
         r_best_chunk <= '1;
         r_best_key   <= '0;
         r_hit        <= 1'b0;
         r_key        <= '0;
         r_key_valid  <= 1'b0;
         for (int i = 0; i < NCORES; i++) r_chunk_id[i] <= '0;
      end else begin
         r_core_en <= w_disp;
         r_busy    <= w_busy_nxt;
         if (|w_disp) begin
            r_core_base <= w_base;
            r_core_last <= w_base | C_SPAN;
         end
         if (w_accept) begin
            r_next_chunk <= '0;
            r_best_chunk <= '1;
            r_best_key   <= '0;
            r_hit        <= 1'b0;
            r_key        <= '0;
            r_key_valid  <= 1'b0;
         end else if (r_state == RUN) begin
            r_next_chunk <= w_next_chunk_nxt;
            if (w_best_upd) begin
               r_best_key   <= w_min_key;
               r_best_chunk <= w_min_chunk;
               r_hit        <= 1'b1;
            end
         end else if (r_state == DONE) begin
            r_key       <= r_best_key;
            r_key_valid <= r_hit;
         end
         for (int i = 0; i < NCORES; i++) begin
            if (w_disp[i]) r_chunk_id[i] <= r_next_chunk;
            r_abort[i] <= r_abort[i] ? !i_core_rdy[i]
                                     : (r_busy[i] && !w_done_ok[i] && r_chunk_id[i] > r_best_chunk);
         end
      end
   end

`ifdef CRACK_SCHED_PROGRESS_EN
   logic [CW-1:0] r_chunks_done;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)         r_chunks_done <= '0;
      else if (w_accept) r_chunks_done <= '0;
      else               r_chunks_done <= r_chunks_done + CW'($countones(w_done_ok))
                                                        + CW'($countones(w_abort_clr));
   end

   assign o_chunks_done = r_chunks_done;
`endif

   assign o_key        = r_key;
   assign o_key_valid  = r_key_valid;
   assign o_core_en    = r_core_en;
   assign o_core_base  = r_core_base;
   assign o_core_last  = r_core_last;
   assign o_core_abort = r_abort;

endmodule

// File: tb/tb_crack_scheduler.sv
// tb/tb_crack_scheduler.sv - directed bench for crack_scheduler driving two stub crack cores
module tb_crack_scheduler;

   localparam int NC = 2;
   localparam int KW = 24;
   localparam int CL = 22;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en  = 1'b0;
   logic             rdy, key_valid;
   logic [KW-1:0]    key, core_base, core_last;
   logic [NC-1:0]    core_en, core_abort, core_rdy, core_done, core_found;
   logic [NC*KW-1:0] core_key;
`ifdef CRACK_SCHED_PROGRESS_EN
   logic [KW-CL:0]   chunks_done;
`endif

   always #5 clk = ~clk;

   crack_scheduler #(.NCORES(NC), .KEY_W(KW), .CHUNK_LOG2(CL)) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_en         (en),
      .o_rdy        (rdy),
      .o_key        (key),
      .o_key_valid  (key_valid),
      .o_core_en    (core_en),
      .o_core_base  (core_base),
      .o_core_last  (core_last),
      .o_core_abort (core_abort),
      .i_core_rdy   (core_rdy),
      .i_core_done  (core_done),
      .i_core_found (core_found),
      .i_core_key   (core_key)
`ifdef CRACK_SCHED_PROGRESS_EN
      ,
      .o_chunks_done(chunks_done)
`endif
   );

   int            n_test = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            last_done_cyc = 0;
   bit            abort_seen = 1'b0;
   logic [KW-1:0] disp_q [$];

   int            lat [NC];
   logic [KW-1:0] hk [2];
   logic [1:0]    hk_v = '0;
   int            cnt [NC];
   logic [KW-1:0] s_base [NC];
   logic [KW-1:0] s_last [NC];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_test++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [KW:0] probe(input logic [KW-1:0] b, input logic [KW-1:0] l);
      logic [KW:0] r = '0;
      for (int j = 0; j < 2; j++)
         if (hk_v[j] && hk[j] >= b && hk[j] <= l && (!r[KW] || hk[j] < r[KW-1:0]))
            r = {1'b1, hk[j]};
      return r;
   endfunction

   // Stub core: lat[i] cycles of work per chunk, reports the lowest programmed key inside its chunk.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         core_rdy   <= '1;
         core_done  <= '0;
         core_found <= '0;
         core_key   <= '0;
         for (int i = 0; i < NC; i++) cnt[i] <= 0;
      end else begin
         for (int i = 0; i < NC; i++) begin
            core_done[i] <= 1'b0;
            if (core_rdy[i] && core_en[i]) begin
               core_rdy[i] <= 1'b0;
               cnt[i]      <= lat[i];
               s_base[i]   <= core_base;
               s_last[i]   <= core_last;
            end else if (!core_rdy[i]) begin
               if (core_abort[i]) begin
                  core_rdy[i] <= 1'b1;
               end else if (cnt[i] == 0) begin
                  core_done[i] <= 1'b1;
                  core_rdy[i]  <= 1'b1;
                  {core_found[i], core_key[i*KW +: KW]} <= probe(s_base[i], s_last[i]);
               end else begin
                  cnt[i] <= cnt[i] - 1;
               end
            end
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (|core_done)  last_done_cyc = cyc;
         if (|core_abort) abort_seen = 1'b1;
         for (int i = 0; i < NC; i++) begin
            if (core_en[i]) begin
               disp_q.push_back(core_base);
               check("core_last", 32'(core_last), 32'(core_base) + 32'h3FFFFF);
            end
         end
      end
   end

   task automatic setup(input int l0, input int l1, input logic [1:0] v,
                        input logic [KW-1:0] k0, input logic [KW-1:0] k1);
      lat[0] = l0;
      lat[1] = l1;
      hk_v   = v;
      hk[0]  = k0;
      hk[1]  = k1;
      disp_q.delete();
      abort_seen = 1'b0;
   endtask

   task automatic wait_rdy(input string tag);
      int n = 0;
      while (!rdy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_rdy"}, 32'(rdy), 32'd1);
   endtask

   task automatic run(input string tag);
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      check({tag, "_busy"}, 32'(rdy), 32'd0);
      wait_rdy(tag);
   endtask

   initial begin
      lat[0] = 3;
      lat[1] = 3;
      hk[0]  = '0;
      hk[1]  = '0;
      repeat (3) @(negedge clk);
      check("rst_rdy", 32'(rdy), 32'd1);
      check("rst_key", 32'(key), 32'd0);
      check("rst_key_valid", 32'(key_valid), 32'd0);
      check("rst_core_en", 32'(core_en), 32'd0);
      check("rst_core_abort", 32'(core_abort), 32'd0);
      check("rst_core_base", 32'(core_base), 32'd0);
      check("rst_core_last", 32'(core_last), 32'd0);
      rst = 1'b0;

      // 1: full sweep without a hit, with start and finish latency
      setup(5, 5, 2'b00, '0, '0);
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      check("t1_rdy_low", 32'(rdy), 32'd0);
      check("t1_lat1_core_en", 32'(core_en), 32'd0);
      @(negedge clk);
      check("t1_lat2_core_en", 32'(core_en), 32'd1);
      wait_rdy("t1");
      check("t1_done_to_rdy", 32'(cyc - last_done_cyc), 32'd2);
      check("t1_ndisp", 32'(disp_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < disp_q.size(); i++)
         check("t1_base", 32'(disp_q[i]), 32'(i) << CL);
      check("t1_key_valid", 32'(key_valid), 32'd0);
      check("t1_key", 32'(key), 32'd0);
`ifdef CRACK_SCHED_PROGRESS_EN
      check("t1_chunks_done", 32'(chunks_done), 32'd4);
`endif

      // 2: single hit in chunk 1; chunk 2 aborted, chunk 3 never dispatched
      setup(10, 10, 2'b01, 24'h412345, '0);
      run("t2");
      check("t2_key", 32'(key), 32'h412345);
      check("t2_key_valid", 32'(key_valid), 32'd1);
      check("t2_abort_seen", 32'(abort_seen), 32'd1);
      check("t2_ndisp", 32'(disp_q.size()), 32'd3);

      // 3: late hit in chunk 0 beats earlier hit in chunk 1
      setup(40, 5, 2'b11, 24'h7FFFFF, 24'h000010);
      run("t3");
      check("t3_key", 32'(key), 32'h000010);
      check("t3_key_valid", 32'(key_valid), 32'd1);
      check("t3_ndisp", 32'(disp_q.size()), 32'd2);
      check("t3_abort_seen", 32'(abort_seen), 32'd0);

      // 4: both cores report hits on the same cycle
      setup(11, 10, 2'b11, 24'hC00001, 24'h800002);
      run("t4");
      check("t4_key", 32'(key), 32'h800002);
      check("t4_key_valid", 32'(key_valid), 32'd1);

      // 5: asynchronous reset while a start pulse is out, then clean searches at both key extremes
      setup(20, 20, 2'b00, '0, '0);
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      check("t5_pre_core_en", 32'(core_en), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("t5_rst_core_en", 32'(core_en), 32'd0);
      check("t5_rst_core_abort", 32'(core_abort), 32'd0);
      check("t5_rst_key_valid", 32'(key_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("t5_rdy", 32'(rdy), 32'd1);
      setup(3, 3, 2'b01, 24'hFFFFFF, '0);
      run("t5a");
      check("t5a_key", 32'(key), 32'hFFFFFF);
      check("t5a_key_valid", 32'(key_valid), 32'd1);
      check("t5a_ndisp", 32'(disp_q.size()), 32'd4);
      setup(3, 20, 2'b01, 24'h000000, '0);
      run("t5b");
      check("t5b_key", 32'(key), 32'd0);
      check("t5b_key_valid", 32'(key_valid), 32'd1);
      check("t5b_ndisp", 32'(disp_q.size()), 32'd2);
      check("t5b_abort_seen", 32'(abort_seen), 32'd1);

      // 6: en held high across DONE restarts only once rdy is back
      setup(3, 3, 2'b00, '0, '0);
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      check("t6_rdy_low", 32'(rdy), 32'd0);
      wait_rdy("t6a");
      check("t6a_ndisp", 32'(disp_q.size()), 32'd4);
      check("t6a_key_valid", 32'(key_valid), 32'd0);
      disp_q.delete();
      @(negedge clk);
      en = 1'b0;
      check("t6_restart", 32'(rdy), 32'd0);
      wait_rdy("t6b");
      check("t6b_ndisp", 32'(disp_q.size()), 32'd4);
      if (disp_q.size() > 0) check("t6b_first_base", 32'(disp_q[0]), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
      $finish;
   end

endmodule
